// File: rtl/fifo2_pkg.sv
// Shared constants and types for the fifo2 single-clock FIFO.
package fifo2_pkg;

  localparam int unsigned FIFO2_WIDTH = 8;
  localparam int unsigned FIFO2_DEPTH = 8;

  typedef logic [FIFO2_WIDTH-1:0] data_t;

endpackage

// File: rtl/fifo2_mem.sv
// DEPTH x WIDTH register array: synchronous write port, registered read port.
module fifo2_mem #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8,
  parameter int unsigned AW    = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Storage is deliberately left uncleared by reset.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (rst)     rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/fifo2_sync.sv
// Single-clock FIFO with registered read data and registered empty/full flags.
module fifo2_sync
  import fifo2_pkg::*;
#(
  parameter int unsigned WIDTH = FIFO2_WIDTH,
  parameter int unsigned DEPTH = FIFO2_DEPTH
) (
  input  logic             clk,
  input  logic [WIDTH-1:0] data_in,
  input  logic             wr_en,
  input  logic             rd_en,
  input  logic             rst,
  output logic [WIDTH-1:0] data_out,
  output logic             empty,
  output logic             full
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic [AW:0]   count_next;
  logic          wr_acc;
  logic          rd_acc;

  // A read frees a slot in the same edge, so a full FIFO still accepts wr+rd.
  assign rd_acc = rd_en & ~empty;
  assign wr_acc = wr_en & (~full | rd_acc);

  always_comb begin
    count_next = count;
    if (wr_acc && !rd_acc)      count_next = count + (AW+1)'(1);
    else if (rd_acc && !wr_acc) count_next = count - (AW+1)'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      empty  <= 1'b1;
      full   <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + AW'(1);
      if (rd_acc) rd_ptr <= rd_ptr + AW'(1);
      count <= count_next;
      empty <= (count_next == '0);
      full  <= (count_next == (AW+1)'(DEPTH));
    end
  end

  fifo2_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk   (clk),
    .rst   (rst),
    .we    (wr_acc & ~rst),
    .waddr (wr_ptr),
    .wdata (data_in),
    .re    (rd_acc),
    .raddr (rd_ptr),
    .rdata (data_out)
  );

endmodule

// File: tb/tb_fifo2_sync.sv
// Randomized and directed bench for fifo2_sync against a queue-based FIFO model.
module tb_fifo2_sync;
  import fifo2_pkg::*;

  localparam int unsigned DEPTH = FIFO2_DEPTH;

  logic  clk = 1'b0;
  data_t data_in = '0;
  logic  wr_en = 1'b0;
  logic  rd_en = 1'b0;
  logic  rst = 1'b0;
  data_t data_out;
  logic  empty;
  logic  full;

  fifo2_sync #(
    .WIDTH (FIFO2_WIDTH),
    .DEPTH (DEPTH)
  ) dut (
    .clk      (clk),
    .data_in  (data_in),
    .wr_en    (wr_en),
    .rd_en    (rd_en),
    .rst      (rst),
    .data_out (data_out),
    .empty    (empty),
    .full     (full)
  );

  always #5 clk = ~clk;

  data_t q[$];
  data_t exp_dout = '0;
  logic  checking = 1'b0;
  int    errors = 0;
  int    checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (checking) begin
      chk("model_data_out", 32'(data_out), 32'(exp_dout));
      chk("model_empty", 32'(empty), 32'(q.size() == 0));
      chk("model_full", 32'(full), 32'(q.size() == DEPTH));
    end
  end

  // Drive one cycle from a negedge, update the model at the posedge, return at the next negedge.
  task automatic step(input logic w, input logic r, input data_t d, input logic rs);
    logic rd_ok;
    logic wr_ok;
    wr_en = w; rd_en = r; data_in = d; rst = rs;
    @(posedge clk);
    if (rs) begin
      q.delete();
      exp_dout = '0;
    end else begin
      rd_ok = r && (q.size() > 0);
      wr_ok = w && ((q.size() < DEPTH) || rd_ok);
      if (rd_ok) exp_dout = q.pop_front();
      if (wr_ok) q.push_back(d);
    end
    @(negedge clk);
    wr_en = 1'b0; rd_en = 1'b0; rst = 1'b0;
  endtask

  initial begin
    @(negedge clk);
    step(1'b0, 1'b0, 8'h00, 1'b1);
    checking = 1'b1;
    chk("reset_dout", 32'(data_out), 32'h00);
    chk("reset_empty", 32'(empty), 32'd1);
    chk("reset_full", 32'(full), 32'd0);

    step(1'b0, 1'b1, 8'h00, 1'b0);
    step(1'b0, 1'b1, 8'h00, 1'b0);
    chk("underflow_dout", 32'(data_out), 32'h00);
    chk("underflow_empty", 32'(empty), 32'd1);

    for (int i = 1; i <= 8; i++) begin
      step(1'b1, 1'b0, data_t'(i * 'h11), 1'b0);
      if (i == 1) chk("fill_empty_falls", 32'(empty), 32'd0);
      if (i == 7) chk("fill_not_full_at7", 32'(full), 32'd0);
    end
    chk("fill_full", 32'(full), 32'd1);
    step(1'b1, 1'b0, 8'h99, 1'b0);
    chk("overflow_full", 32'(full), 32'd1);

    for (int i = 1; i <= 8; i++) begin
      step(1'b0, 1'b1, 8'h00, 1'b0);
      if (i == 1) chk("drain_first", 32'(data_out), 32'h11);
      if (i == 1) chk("drain_full_falls", 32'(full), 32'd0);
    end
    chk("drain_last", 32'(data_out), 32'h88);
    chk("drain_empty", 32'(empty), 32'd1);
    step(1'b0, 1'b1, 8'h00, 1'b0);
    chk("drain_hold", 32'(data_out), 32'h88);

    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, data_t'($urandom), 1'b0);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 8'h00, 1'b0);
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0, data_t'(8'hA0 + i), 1'b0);
    step(1'b0, 1'b1, 8'h00, 1'b0);
    chk("wrap_first", 32'(data_out), 32'hA0);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 8'h00, 1'b0);
    chk("wrap_last", 32'(data_out), 32'hA5);
    chk("wrap_empty", 32'(empty), 32'd1);

    step(1'b1, 1'b1, 8'h5A, 1'b0);
    chk("simul_empty_dout", 32'(data_out), 32'hA5);
    chk("simul_empty_flag", 32'(empty), 32'd0);
    step(1'b0, 1'b1, 8'h00, 1'b0);
    chk("simul_empty_read", 32'(data_out), 32'h5A);

    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, data_t'(8'hC0 + i), 1'b0);
    step(1'b1, 1'b1, 8'hD0, 1'b0);
    chk("simul_full_dout", 32'(data_out), 32'hC0);
    chk("simul_full_flag", 32'(full), 32'd1);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 8'h00, 1'b0);
    step(1'b1, 1'b1, 8'hE0, 1'b0);
    chk("simul_mid_dout", 32'(data_out), 32'hC6);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 8'h00, 1'b0);
    chk("simul_mid_last", 32'(data_out), 32'hE0);
    chk("simul_mid_empty", 32'(empty), 32'd1);

    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, data_t'(8'h70 + i), 1'b0);
    step(1'b0, 1'b1, 8'h00, 1'b0);
    step(1'b1, 1'b1, 8'hFF, 1'b1);
    chk("midrst_dout", 32'(data_out), 32'h00);
    chk("midrst_empty", 32'(empty), 32'd1);
    chk("midrst_full", 32'(full), 32'd0);
    step(1'b1, 1'b0, 8'h3C, 1'b0);
    step(1'b0, 1'b1, 8'h00, 1'b0);
    chk("midrst_readback", 32'(data_out), 32'h3C);

    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 99) < 55), ($urandom_range(0, 99) < 50),
           data_t'($urandom), ($urandom_range(0, 199) == 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
